// File: rtl/arbitro_somador_pkg.sv
// -----------------------------------------------------------------------------
// arbitro_somador_pkg
// Shared definitions for the two-requester adder arbiter:
//   estado_t  - controller state encoding (IDLE / CALC / RESP)
//   BCD_BASE  - radix used to split the sum into tens/units digits
//   N_REQ     - number of requesters sharing the adder
// -----------------------------------------------------------------------------
package arbitro_somador_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        RESP = 2'd2
    } estado_t;

    localparam int BCD_BASE = 10;
    localparam int N_REQ    = 2;

endpackage

// File: rtl/arbitro_somador_ripple.sv
// -----------------------------------------------------------------------------
// somador_ripple_n
// WIDTH-bit ripple-carry adder built from a chain of full-adder cells.
// Ports:
//   a, b  [WIDTH-1:0]  operands
//   cin                carry into bit 0
//   sum   [WIDTH-1:0]  sum bits
//   cout               carry out of the MSB cell
// -----------------------------------------------------------------------------
module somador_ripple_n #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    // carry_s[i] is the carry into cell i; carry_s[WIDTH] leaves the chain
    logic [WIDTH:0] carry_s;

    assign carry_s[0] = cin;

    genvar i;
    generate
        for (i = 0; i < WIDTH; i++) begin : g_fa
            assign sum[i]       = a[i] ^ b[i] ^ carry_s[i];
            assign carry_s[i+1] = (a[i] & b[i]) | (carry_s[i] & (a[i] ^ b[i]));
        end
    endgenerate

    assign cout = carry_s[WIDTH];

endmodule

// File: rtl/arbitro_somador.sv
// -----------------------------------------------------------------------------
// arbitro_somador
// Arbitrates two requesters onto one shared ripple-carry adder. A granted
// operand pair is registered in IDLE, summed in CALC and presented as a
// tagged response in RESP, where it is held until the consumer accepts it.
// The registered sum is also split into BCD tens/units digits for the
// downstream HEX1/HEX0 seven-segment decoders.
//
// Build option:
//   ARB_FIXED_PRIO_EN defined   -> requester 0 always wins a tie, no pointer
//   ARB_FIXED_PRIO_EN undefined -> round-robin (default)
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   req0_valid/a/b/cin, req0_ready  requester 0 handshake and operands
//   req1_valid/a/b/cin, req1_ready  requester 1 handshake and operands
//   rsp_valid, rsp_ready          response handshake
//   rsp_id                        requester that owns the response
//   rsp_sum [WIDTH:0]             a + b + cin, carry-out in MSB
//   rsp_dezena, rsp_unidade       BCD tens / units digits of rsp_sum
//   busy                          controller is outside IDLE
// -----------------------------------------------------------------------------
module arbitro_somador
    import arbitro_somador_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic             req0_cin,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic             req1_cin,
    output logic             req1_ready,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [WIDTH:0]   rsp_sum,
    output logic [3:0]       rsp_dezena,
    output logic [3:0]       rsp_unidade,
    output logic             busy
);

    // Tens digit in the upper nibble, units digit in the lower nibble.
    // Sums never exceed 63, so a 7-bit argument covers every legal WIDTH.
    function automatic logic [7:0] bcd_split(input logic [6:0] v);
        return {4'(v / 7'(BCD_BASE)), 4'(v % 7'(BCD_BASE))};
    endfunction

    estado_t            state_r;
    estado_t            state_next_s;
    logic [N_REQ-1:0]   grant_s;

    logic [WIDTH-1:0]   op_a_r;
    logic [WIDTH-1:0]   op_b_r;
    logic               op_cin_r;
    logic               op_id_r;

    logic [WIDTH-1:0]   soma_s;
    logic               cout_s;
    logic [WIDTH:0]     sum_s;
    logic [7:0]         bcd_s;

    logic               rsp_valid_r;
    logic               rsp_id_r;
    logic [WIDTH:0]     rsp_sum_r;
    logic [3:0]         rsp_dezena_r;
    logic [3:0]         rsp_unidade_r;
    logic               busy_r;

`ifndef ARB_FIXED_PRIO_EN
    // 0: requester 0 wins the next tie, 1: requester 1 wins it
    logic               prio_r;
`endif

    somador_ripple_n #(
        .WIDTH (WIDTH)
    ) u_somador (
        .a    (op_a_r),
        .b    (op_b_r),
        .cin  (op_cin_r),
        .sum  (soma_s),
        .cout (cout_s)
    );

    assign sum_s = {cout_s, soma_s};
    assign bcd_s = bcd_split(7'(sum_s));

    // Grant selection: only in IDLE, never while reset is being applied
    always_comb begin
        grant_s = {N_REQ{1'b0}};
        if (rst) begin
            grant_s = {N_REQ{1'b0}};
        end else if (state_r == IDLE) begin
            if (req0_valid && req1_valid) begin
`ifdef ARB_FIXED_PRIO_EN
                grant_s = 2'b01;
`else
                if (prio_r) begin
                    grant_s = 2'b10;
                end else begin
                    grant_s = 2'b01;
                end
`endif
            end else if (req0_valid) begin
                grant_s = 2'b01;
            end else if (req1_valid) begin
                grant_s = 2'b10;
            end else begin
                grant_s = 2'b00;
            end
        end else begin
            grant_s = {N_REQ{1'b0}};
        end
    end

    // Next-state logic for the IDLE -> CALC -> RESP -> IDLE sequence
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (|grant_s) begin
                    state_next_s = CALC;
                end else begin
                    state_next_s = IDLE;
                end
            end
            CALC: begin
                state_next_s = RESP;
            end
            RESP: begin
                if (rsp_ready) begin
                    state_next_s = IDLE;
                end else begin
                    state_next_s = RESP;
                end
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Operand capture, result registration and response handshake
    always_ff @(posedge clk) begin
        if (rst) begin
            op_a_r        <= {WIDTH{1'b0}};
            op_b_r        <= {WIDTH{1'b0}};
            op_cin_r      <= 1'b0;
            op_id_r       <= 1'b0;
            rsp_valid_r   <= 1'b0;
            rsp_id_r      <= 1'b0;
            rsp_sum_r     <= {(WIDTH+1){1'b0}};
            rsp_dezena_r  <= 4'd0;
            rsp_unidade_r <= 4'd0;
            busy_r        <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (grant_s[1]) begin
                        op_a_r   <= req1_a;
                        op_b_r   <= req1_b;
                        op_cin_r <= req1_cin;
                        op_id_r  <= 1'b1;
                    end else if (grant_s[0]) begin
                        op_a_r   <= req0_a;
                        op_b_r   <= req0_b;
                        op_cin_r <= req0_cin;
                        op_id_r  <= 1'b0;
                    end
                end
                CALC: begin
                    rsp_sum_r     <= sum_s;
                    rsp_dezena_r  <= bcd_s[7:4];
                    rsp_unidade_r <= bcd_s[3:0];
                    rsp_id_r      <= op_id_r;
                    rsp_valid_r   <= 1'b1;
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_r <= 1'b0;
                    end
                end
                default: begin
                    rsp_valid_r <= 1'b0;
                end
            endcase
            // busy tracks the state being entered so it lines up with state_r
            busy_r <= (state_next_s != IDLE);
        end
    end

`ifndef ARB_FIXED_PRIO_EN
    // Hand priority to the other requester once a response is consumed
    always_ff @(posedge clk) begin
        if (rst) begin
            prio_r <= 1'b0;
        end else if ((state_r == RESP) && rsp_ready) begin
            prio_r <= ~rsp_id_r;
        end
    end
`endif

    assign req0_ready  = grant_s[0];
    assign req1_ready  = grant_s[1];
    assign rsp_valid   = rsp_valid_r;
    assign rsp_id      = rsp_id_r;
    assign rsp_sum     = rsp_sum_r;
    assign rsp_dezena  = rsp_dezena_r;
    assign rsp_unidade = rsp_unidade_r;
    assign busy        = busy_r;

endmodule

// File: tb/tb_arbitro_somador.sv
// -----------------------------------------------------------------------------
// tb_arbitro_somador
// Self-checking bench for arbitro_somador (WIDTH = 4). Expected responses come
// from plain arithmetic (a + b + cin, /10, %10) and a one-variable model of
// which requester is owed the next tie.
// -----------------------------------------------------------------------------
module tb_arbitro_somador;

    localparam int W = 4;
`ifdef ARB_FIXED_PRIO_EN
    localparam bit FIXED = 1'b1;
`else
    localparam bit FIXED = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst;
    logic         req0_valid, req0_cin, req0_ready;
    logic [W-1:0] req0_a, req0_b;
    logic         req1_valid, req1_cin, req1_ready;
    logic [W-1:0] req1_a, req1_b;
    logic         rsp_valid, rsp_ready, rsp_id, busy;
    logic [W:0]   rsp_sum;
    logic [3:0]   rsp_dezena, rsp_unidade;

    int total = 0;
    int bad   = 0;
    int prio_exp = 0;   // requester owed the next tie (round-robin model)

    always #5 clk = ~clk;

    arbitro_somador #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_a(req0_a), .req0_b(req0_b),
        .req0_cin(req0_cin), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_a(req1_a), .req1_b(req1_b),
        .req1_cin(req1_cin), .req1_ready(req1_ready),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_sum(rsp_sum), .rsp_dezena(rsp_dezena), .rsp_unidade(rsp_unidade),
        .busy(busy)
    );

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive0(input bit v, input int a, input int b, input bit c);
        req0_valid = v; req0_a = a[W-1:0]; req0_b = b[W-1:0]; req0_cin = c;
    endtask

    task automatic drive1(input bit v, input int a, input int b, input bit c);
        req1_valid = v; req1_a = a[W-1:0]; req1_b = b[W-1:0]; req1_cin = c;
    endtask

    task automatic test_reset();
        rst = 1'b1; rsp_ready = 1'b0;
        drive0(1'b0, 0, 0, 1'b0); drive1(1'b0, 0, 0, 1'b0);
        cyc();
        drive0(1'b1, 1, 1, 1'b0); drive1(1'b1, 2, 2, 1'b0);
        #1;
        total++;
        if ({req0_ready, req1_ready} !== 2'b00) begin
            bad++; $display("FAIL reset_ready: got %b expected 00", {req0_ready, req1_ready});
        end
        cyc();
        drive0(1'b0, 0, 0, 1'b0); drive1(1'b0, 0, 0, 1'b0);
        #1;
        total++;
        if ({rsp_valid, rsp_id, rsp_sum, rsp_dezena, rsp_unidade, busy} !== 16'd0) begin
            bad++;
            $display("FAIL reset_outputs: got v=%b id=%b sum=%0d d=%0d u=%0d busy=%b expected all 0",
                     rsp_valid, rsp_id, rsp_sum, rsp_dezena, rsp_unidade, busy);
        end
        rst = 1'b0;
        prio_exp = 0;
        cyc(); #1;
        total++;
        if ({req0_ready, req1_ready, busy} !== 3'b000) begin
            bad++; $display("FAIL idle_no_req: got rdy/busy %b expected 000", {req0_ready, req1_ready, busy});
        end
    endtask

    task automatic test_single();
        cyc();
        drive0(1'b1, 9, 7, 1'b1);
        #1;
        total++;
        if ({req0_ready, req1_ready} !== 2'b10) begin
            bad++; $display("FAIL single_grant: got %b expected 10", {req0_ready, req1_ready});
        end
        cyc();
        drive0(1'b0, 0, 0, 1'b0);
        #1;
        total++;
        if ({rsp_valid, busy, req0_ready} !== 3'b010) begin
            bad++; $display("FAIL single_calc: got v/busy/rdy %b expected 010", {rsp_valid, busy, req0_ready});
        end
        cyc(); #1;
        total++;
        if ({rsp_valid, rsp_id, rsp_sum, rsp_dezena, rsp_unidade} !== {1'b1, 1'b0, 5'd17, 4'd1, 4'd7}) begin
            bad++;
            $display("FAIL single_rsp: got v=%b id=%b sum=%0d d=%0d u=%0d expected 1 0 17 1 7",
                     rsp_valid, rsp_id, rsp_sum, rsp_dezena, rsp_unidade);
        end
        rsp_ready = 1'b1;
        cyc();
        rsp_ready = 1'b0;
        #1;
        total++;
        if ({rsp_valid, busy} !== 2'b00) begin
            bad++; $display("FAIL single_done: got v/busy %b expected 00", {rsp_valid, busy});
        end
        prio_exp = 1;
    endtask

    task automatic test_overflow();
        cyc();
        drive1(1'b1, 15, 15, 1'b1);
        #1;
        total++;
        if ({req0_ready, req1_ready} !== 2'b01) begin
            bad++; $display("FAIL ovf_grant: got %b expected 01", {req0_ready, req1_ready});
        end
        cyc();
        drive1(1'b0, 0, 0, 1'b0);
        cyc(); #1;
        total++;
        if ({rsp_valid, rsp_id, rsp_sum, rsp_dezena, rsp_unidade} !== {1'b1, 1'b1, 5'b11111, 4'd3, 4'd1}) begin
            bad++;
            $display("FAIL ovf_rsp: got v=%b id=%b sum=%0d d=%0d u=%0d expected 1 1 31 3 1",
                     rsp_valid, rsp_id, rsp_sum, rsp_dezena, rsp_unidade);
        end
        rsp_ready = 1'b1;
        cyc();
        rsp_ready = 1'b0;
        prio_exp = 0;
    endtask

    task automatic test_contention();
        int got;
        int exp_id;
        int s;
        got = 0;
        cyc();
        drive0(1'b1, 3, 4, 1'b0);
        drive1(1'b1, 8, 8, 1'b0);
        rsp_ready = 1'b1;
        for (int k = 0; k < 30 && got < 3; k++) begin
            #1;
            total++;
            if (req0_ready && req1_ready) begin
                bad++; $display("FAIL cont_both_ready: got 11 expected at most one");
            end
            if (rsp_valid === 1'b1) begin
                exp_id = FIXED ? 0 : prio_exp;
                s = (exp_id == 0) ? (3 + 4) : (8 + 8);
                total++;
                if ({rsp_id, rsp_sum, rsp_dezena, rsp_unidade} !==
                    {exp_id[0], s[4:0], 4'(s / 10), 4'(s % 10)}) begin
                    bad++;
                    $display("FAIL cont_rsp%0d: got id=%b sum=%0d d=%0d u=%0d expected id=%0d sum=%0d",
                             got, rsp_id, rsp_sum, rsp_dezena, rsp_unidade, exp_id, s);
                end
                prio_exp = 1 - exp_id;
                got++;
            end
            if (got < 3) cyc();
        end
        total++;
        if (got != 3) begin
            bad++; $display("FAIL cont_timeout: got %0d responses expected 3", got);
        end
        drive0(1'b0, 0, 0, 1'b0);
        drive1(1'b0, 0, 0, 1'b0);
        cyc();
        rsp_ready = 1'b0;
    endtask

    task automatic test_back_pressure();
        cyc();
        drive0(1'b1, 9, 9, 1'b0);
        #1;
        total++;
        if (req0_ready !== 1'b1) begin
            bad++; $display("FAIL bp_grant: got %b expected 1", req0_ready);
        end
        cyc();
        drive0(1'b0, 0, 0, 1'b0);
        drive1(1'b1, 5, 6, 1'b0);
        #1;
        total++;
        if (req1_ready !== 1'b0) begin
            bad++; $display("FAIL bp_calc_ready: got %b expected 0", req1_ready);
        end
        cyc();
        for (int k = 0; k < 5; k++) begin
            #1;
            total++;
            if ({rsp_valid, rsp_id, rsp_sum, rsp_dezena, rsp_unidade, busy, req1_ready} !==
                {1'b1, 1'b0, 5'd18, 4'd1, 4'd8, 1'b1, 1'b0}) begin
                bad++;
                $display("FAIL bp_hold%0d: got v=%b id=%b sum=%0d d=%0d u=%0d busy=%b rdy1=%b expected 1 0 18 1 8 1 0",
                         k, rsp_valid, rsp_id, rsp_sum, rsp_dezena, rsp_unidade, busy, req1_ready);
            end
            if (k < 4) cyc();
        end
        rsp_ready = 1'b1;
        cyc();
        rsp_ready = 1'b0;
        prio_exp = 1;
        #1;
        total++;
        if ({rsp_valid, req1_ready} !== 2'b01) begin
            bad++; $display("FAIL bp_release: got v/rdy1 %b expected 01", {rsp_valid, req1_ready});
        end
        cyc();
        drive1(1'b0, 0, 0, 1'b0);
        cyc(); #1;
        total++;
        if ({rsp_valid, rsp_id, rsp_sum, rsp_dezena, rsp_unidade} !== {1'b1, 1'b1, 5'd11, 4'd1, 4'd1}) begin
            bad++;
            $display("FAIL bp_second: got v=%b id=%b sum=%0d d=%0d u=%0d expected 1 1 11 1 1",
                     rsp_valid, rsp_id, rsp_sum, rsp_dezena, rsp_unidade);
        end
        rsp_ready = 1'b1;
        cyc();
        rsp_ready = 1'b0;
        prio_exp = 0;
    endtask

    task automatic test_reset_mid();
        // serve requester 0 so the round-robin pointer moves to requester 1
        cyc();
        drive0(1'b1, 2, 3, 1'b0);
        cyc();
        drive0(1'b0, 0, 0, 1'b0);
        cyc(); #1;
        total++;
        if ({rsp_valid, rsp_sum} !== {1'b1, 5'd5}) begin
            bad++; $display("FAIL mid_pre: got v=%b sum=%0d expected 1 5", rsp_valid, rsp_sum);
        end
        rsp_ready = 1'b1;
        cyc();
        rsp_ready = 1'b0;
        drive1(1'b1, 7, 7, 1'b1);
        #1;
        total++;
        if (req1_ready !== 1'b1) begin
            bad++; $display("FAIL mid_grant: got %b expected 1", req1_ready);
        end
        cyc();
        drive1(1'b0, 0, 0, 1'b0);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        prio_exp = 0;
        #1;
        total++;
        if ({rsp_valid, busy} !== 2'b00) begin
            bad++; $display("FAIL mid_flush: got v/busy %b expected 00", {rsp_valid, busy});
        end
        cyc(); #1;
        total++;
        if (rsp_valid !== 1'b0) begin
            bad++; $display("FAIL mid_no_rsp: got %b expected 0", rsp_valid);
        end
        drive0(1'b1, 1, 1, 1'b0);
        drive1(1'b1, 6, 6, 1'b0);
        #1;
        total++;
        if ({req0_ready, req1_ready} !== 2'b10) begin
            bad++; $display("FAIL mid_prio0: got %b expected 10", {req0_ready, req1_ready});
        end
        cyc();
        drive0(1'b0, 0, 0, 1'b0);
        cyc(); #1;
        total++;
        if ({rsp_valid, rsp_id, rsp_sum} !== {1'b1, 1'b0, 5'd2}) begin
            bad++; $display("FAIL mid_rsp0: got v=%b id=%b sum=%0d expected 1 0 2", rsp_valid, rsp_id, rsp_sum);
        end
        rsp_ready = 1'b1;
        cyc();
        rsp_ready = 1'b0;
        prio_exp = 1;
        #1;
        total++;
        if (req1_ready !== 1'b1) begin
            bad++; $display("FAIL mid_loser: got %b expected 1", req1_ready);
        end
        cyc();
        drive1(1'b0, 0, 0, 1'b0);
        cyc(); #1;
        total++;
        if ({rsp_valid, rsp_id, rsp_sum, rsp_dezena, rsp_unidade} !== {1'b1, 1'b1, 5'd12, 4'd1, 4'd2}) begin
            bad++;
            $display("FAIL mid_rsp1: got v=%b id=%b sum=%0d d=%0d u=%0d expected 1 1 12 1 2",
                     rsp_valid, rsp_id, rsp_sum, rsp_dezena, rsp_unidade);
        end
        rsp_ready = 1'b1;
        cyc();
        rsp_ready = 1'b0;
        prio_exp = 0;
    endtask

    task automatic test_random();
        bit v0, v1, c0, c1;
        int a0, b0, a1, b1, exp_id, s, stall;
        for (int it = 0; it < 40; it++) begin
            v0 = 1'($urandom_range(0, 1)); v1 = 1'($urandom_range(0, 1));
            a0 = $urandom_range(0, 15); b0 = $urandom_range(0, 15); c0 = 1'($urandom_range(0, 1));
            a1 = $urandom_range(0, 15); b1 = $urandom_range(0, 15); c1 = 1'($urandom_range(0, 1));
            cyc();
            if (!v0 && !v1) begin
                // a stray rsp_ready with no response pending must be ignored
                rsp_ready = 1'b1;
                #1;
                total++;
                if ({req0_ready, req1_ready, busy, rsp_valid} !== 4'b0000) begin
                    bad++; $display("FAIL rnd_idle%0d: got %b expected 0000", it,
                                    {req0_ready, req1_ready, busy, rsp_valid});
                end
                cyc();
                rsp_ready = 1'b0;
                continue;
            end
            drive0(v0, a0, b0, c0);
            drive1(v1, a1, b1, c1);
            exp_id = (v0 && v1) ? (FIXED ? 0 : prio_exp) : (v0 ? 0 : 1);
            s = (exp_id == 0) ? (a0 + b0 + int'(c0)) : (a1 + b1 + int'(c1));
            #1;
            total++;
            if ({req0_ready, req1_ready} !== {exp_id == 0, exp_id == 1}) begin
                bad++; $display("FAIL rnd_grant%0d: got %b expected winner %0d", it,
                                {req0_ready, req1_ready}, exp_id);
            end
            cyc();
            drive0(1'b0, 0, 0, 1'b0);
            drive1(1'b0, 0, 0, 1'b0);
            cyc();
            stall = $urandom_range(0, 3);
            for (int k = 0; k <= stall; k++) begin
                #1;
                total++;
                if ({rsp_valid, rsp_id, rsp_sum, rsp_dezena, rsp_unidade} !==
                    {1'b1, exp_id[0], s[4:0], 4'(s / 10), 4'(s % 10)}) begin
                    bad++;
                    $display("FAIL rnd_rsp%0d: got v=%b id=%b sum=%0d d=%0d u=%0d expected id=%0d sum=%0d",
                             it, rsp_valid, rsp_id, rsp_sum, rsp_dezena, rsp_unidade, exp_id, s);
                end
                if (k < stall) cyc();
            end
            rsp_ready = 1'b1;
            cyc();
            rsp_ready = 1'b0;
            prio_exp = 1 - exp_id;
            #1;
            total++;
            if (rsp_valid !== 1'b0) begin
                bad++; $display("FAIL rnd_done%0d: got %b expected 0", it, rsp_valid);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_overflow();
        test_contention();
        test_back_pressure();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
